// File: rtl/cordic_ci_master.sv
// Sequencer that feeds single-precision angles to a CORDIC custom-instruction unit and queues
// the cosine results in a small FIFO. Optional watchdog enabled by CORDIC_CI_TIMEOUT_EN.
module cordic_ci_master #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [31:0] ci_dataa,
  input  logic [31:0] ci_result,
  input  logic        ci_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [31:0]       dataa_q, dataa_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic              accept, push, pop;
  logic [31:0]       push_data;

`ifdef CORDIC_CI_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       timeout_err_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    dataa_d   = dataa_q;
    push      = 1'b0;
    push_data = ci_result;
    ci_start  = 1'b0;
    ci_clk_en = 1'b0;
`ifdef CORDIC_CI_TIMEOUT_EN
    wdog_d    = '0;
    timeout_d = 1'b0;
`endif
    // A free slot is reserved before issue, so a completing op can always push.
    in_ready  = (state_q == StIdle) && (count_q < CntW'(FIFO_DEPTH));
    accept    = in_valid & in_ready;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          dataa_d = in_data;
        end
      end
      StIssue: begin
        ci_start  = 1'b1;
        ci_clk_en = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        ci_clk_en = 1'b1;
        if (ci_done) begin
          push    = 1'b1;
          state_d = StIdle;
        end
`ifdef CORDIC_CI_TIMEOUT_EN
        else if (wdog_q == 8'(TIMEOUT_CYCLES - 1)) begin
          push      = 1'b1;
          push_data = 32'h7FC0_0000;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign ci_dataa  = dataa_q;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q  <= StIdle;
      dataa_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      dataa_q <= dataa_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push && !aclr) mem_q[wr_ptr_q] <= push_data;
  end

`ifdef CORDIC_CI_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (aclr) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
